// File: rtl/alu_issue_pkg.sv
// Shared constants for the alu issue stage: widths, card codes, carry-in select encodings.
package alu_issue_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [4:0] CARD_NOP = 5'b00000;
  localparam logic [4:0] CARD_ADD = 5'b00001;

  localparam logic [1:0] CIN_ZERO = 2'b00;
  localparam logic [1:0] CIN_ONE  = 2'b01;
  localparam logic [1:0] CIN_FLAG = 2'b10;

  // The reserved encoding 2'b11 falls through to a zero carry-in.
  function automatic logic select_cin(input logic [1:0] sel, input logic flag);
    logic cin;
    case (sel)
      CIN_ZERO: cin = 1'b0;
      CIN_ONE:  cin = 1'b1;
      CIN_FLAG: cin = flag;
      default:  cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Register file: two async read ports plus a debug port, one sync write port, x0 reads zero.
module alu_issue_stage_regfile
  import alu_issue_pkg::*;
#(
  parameter int DW   = DATA_W,
  parameter int NR   = NREG,
  parameter int AW   = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata2,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs [NR];

  // Sync clear on reset; writes to x0 are dropped so it stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        regs[i] <= {DW{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == {AW{1'b0}}) ? {DW{1'b0}} : regs[raddr1];
  assign rdata2   = (raddr2   == {AW{1'b0}}) ? {DW{1'b0}} : regs[raddr2];
  assign dbg_data = (dbg_addr == {AW{1'b0}}) ? {DW{1'b0}} : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch / writeback stage around an external combinational alu.
// EX register feeds the alu; the alu result is committed to the register file one edge later.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int NR = NREG,
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_card,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  input  logic [1:0]    in_cin_sel,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic          alu_Cin,
  output logic [4:0]    alu_Card,
  input  logic [DW-1:0] alu_F,
  input  logic          alu_Cout,
  input  logic          alu_Zero,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          flag_c,
  output logic          flag_z,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic          ex_valid;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          hazard;
  logic          accept;
  logic          commit;

  alu_issue_stage_regfile #(.DW(DW), .NR(NR), .AW(AW)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (commit),
    .waddr    (ex_rd),
    .wdata    (alu_F),
    .raddr1   (in_rs1),
    .rdata1   (rs1_data),
    .raddr2   (in_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign commit = ex_valid && (alu_Card != CARD_NOP);

  // No forwarding: an op reading the pending rd, or the pending carry, waits one cycle.
  always_comb begin
    hazard = 1'b0;
    if (in_valid && commit) begin
      hazard = ((ex_rd != {AW{1'b0}}) && (ex_rd == in_rs1)) ||
               ((ex_rd != {AW{1'b0}}) && !in_use_imm && (ex_rd == in_rs2)) ||
               (in_cin_sel == CIN_FLAG);
    end else begin
      hazard = 1'b0;
    end
  end

  assign in_ready = !hazard;
  assign accept   = in_valid && in_ready;

  // EX register; when nothing is accepted it becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_rd    <= {AW{1'b0}};
      alu_A    <= {DW{1'b0}};
      alu_B    <= {DW{1'b0}};
      alu_Cin  <= 1'b0;
      alu_Card <= CARD_NOP;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_rd    <= in_rd;
      alu_A    <= rs1_data;
      alu_B    <= in_use_imm ? in_imm : rs2_data;
      alu_Cin  <= select_cin(in_cin_sel, flag_c);
      alu_Card <= in_card;
    end else begin
      ex_valid <= 1'b0;
      alu_Card <= CARD_NOP;
    end
  end

  // Writeback pulse and flags; bubbles leave the flags untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= {AW{1'b0}};
      wb_data  <= {DW{1'b0}};
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else if (commit) begin
      wb_valid <= 1'b1;
      wb_rd    <= ex_rd;
      wb_data  <= alu_F;
      flag_c   <= alu_Cout;
      flag_z   <= alu_Zero;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ADD-only alu in the loop.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_card;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [1:0]  in_cin_sel;
  logic [31:0] alu_A, alu_B, alu_F;
  logic        alu_Cin, alu_Cout, alu_Zero;
  logic [4:0]  alu_Card;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flag_c, flag_z;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [32:0] sum;
  assign sum      = {1'b0, alu_A} + {1'b0, alu_B} + {32'd0, alu_Cin};
  assign alu_F    = (alu_Card == CARD_ADD) ? sum[31:0] : 32'h0;
  assign alu_Cout = (alu_Card == CARD_ADD) ? sum[32] : 1'b0;
  assign alu_Zero = (alu_F == 32'h0);

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_card(in_card), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_cin_sel(in_cin_sel),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Card(alu_Card),
    .alu_F(alu_F), .alu_Cout(alu_Cout), .alu_Zero(alu_Zero),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_c(flag_c), .flag_z(flag_z), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [4:0]  card;
    logic [4:0]  rs1, rs2, rd;
    logic        use_imm;
    logic [31:0] imm;
    logic [1:0]  cin_sel;
    logic [31:0] exp_data;
    logic        exp_c, exp_z;
    logic [31:0] exp_dbg;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [4:0] card, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic use_imm, input logic [31:0] imm,
                       input logic [1:0] cin_sel);
    in_valid = 1'b1; in_card = card; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_use_imm = use_imm; in_imm = imm; in_cin_sel = cin_sel;
  endtask

  task automatic idle;
    in_valid = 1'b0; in_card = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_use_imm = 1'b0; in_imm = 32'h0; in_cin_sel = 2'b00;
  endtask

  task automatic peek(input logic [4:0] addr);
    dbg_addr = addr;
    #1;
  endtask

  initial begin
    vecs[0] = '{CARD_ADD, 5'd0, 5'd0, 5'd1,  1'b1, 32'h10,       2'b00, 32'h10, 1'b0, 1'b0, 32'h10};
    vecs[1] = '{CARD_ADD, 5'd1, 5'd1, 5'd7,  1'b0, 32'h0,        2'b00, 32'h20, 1'b0, 1'b0, 32'h20};
    vecs[2] = '{CARD_ADD, 5'd1, 5'd0, 5'd8,  1'b1, 32'hFFFFFFF0, 2'b00, 32'h0,  1'b1, 1'b1, 32'h0};
    vecs[3] = '{CARD_ADD, 5'd0, 5'd0, 5'd9,  1'b1, 32'h5,        2'b10, 32'h6,  1'b0, 1'b0, 32'h6};
    vecs[4] = '{CARD_ADD, 5'd7, 5'd0, 5'd10, 1'b1, 32'h1,        2'b01, 32'h22, 1'b0, 1'b0, 32'h22};
    vecs[5] = '{CARD_ADD, 5'd0, 5'd0, 5'd0,  1'b1, 32'h55,       2'b00, 32'h55, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{CARD_ADD, 5'd1, 5'd0, 5'd11, 1'b1, 32'h0,        2'b11, 32'h10, 1'b0, 1'b0, 32'h10};

    idle();
    dbg_addr = 5'd0;
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
    chk("rst_alu", {alu_A | alu_B}, 32'd0);
    chk("rst_alu_ctl", {26'd0, alu_Cin, alu_Card}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      peek(a[4:0]);
      chk($sformatf("rst_dbg_x%0d", a), dbg_data, 32'd0);
    end

    // Isolated ops from the table
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].card, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].use_imm,
            vecs[i].imm, vecs[i].cin_sel);
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      idle();
      chk($sformatf("v%0d_alu_card", i), {27'd0, alu_Card}, {27'd0, vecs[i].card});
      chk($sformatf("v%0d_wb_early", i), {31'd0, wb_valid}, 32'd0);
      tick();
      peek(vecs[i].rd);
      chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_data);
      chk($sformatf("v%0d_flag_c", i), {31'd0, flag_c}, {31'd0, vecs[i].exp_c});
      chk($sformatf("v%0d_flag_z", i), {31'd0, flag_z}, {31'd0, vecs[i].exp_z});
      chk($sformatf("v%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
    end
    tick();

    // Three independent ops back to back
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        drive(CARD_ADD, 5'd0, 5'd0, 5'(k + 2), 1'b1, 32'(k + 1), 2'b00);
        #1;
        chk($sformatf("b2b_ready%0d", k), {31'd0, in_ready}, 32'd1);
      end else begin
        idle();
      end
      tick();
      if (k >= 1 && k <= 3) begin
        chk($sformatf("b2b_wb_valid%0d", k), {31'd0, wb_valid}, 32'd1);
        chk($sformatf("b2b_wb_rd%0d", k), {27'd0, wb_rd}, 32'(k + 1));
        chk($sformatf("b2b_wb_data%0d", k), wb_data, 32'(k));
      end else begin
        chk($sformatf("b2b_wb_idle%0d", k), {31'd0, wb_valid}, 32'd0);
      end
    end

    // RAW hazard: x5 = x1 + 8, then x6 = x5 + x5
    drive(CARD_ADD, 5'd1, 5'd0, 5'd5, 1'b1, 32'h8, 2'b00);
    tick();
    drive(CARD_ADD, 5'd5, 5'd5, 5'd6, 1'b0, 32'h0, 2'b00);
    #1;
    chk("raw_stall", {31'd0, in_ready}, 32'd0);
    tick();
    chk("raw_release", {31'd0, in_ready}, 32'd1);
    chk("raw_x5_wb", wb_data, 32'h18);
    tick();
    idle();
    chk("raw_gap_wb", {31'd0, wb_valid}, 32'd0);
    tick();
    peek(5'd6);
    chk("raw_x6_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("raw_x6_wb_data", wb_data, 32'h30);
    chk("raw_x6_dbg", dbg_data, 32'h30);
    tick();

    // Carry chain: FFFFFFFF + 1, then 0 + 0 + flag_c
    drive(CARD_ADD, 5'd0, 5'd0, 5'd12, 1'b1, 32'hFFFFFFFF, 2'b01);
    tick();
    drive(CARD_ADD, 5'd0, 5'd0, 5'd13, 1'b1, 32'h0, 2'b10);
    #1;
    chk("carry_stall", {31'd0, in_ready}, 32'd0);
    tick();
    chk("carry_release", {31'd0, in_ready}, 32'd1);
    chk("carry_flags", {30'd0, flag_c, flag_z}, 32'd3);
    chk("carry_wb0", wb_data, 32'h0);
    tick();
    idle();
    tick();
    chk("carry_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("carry_wb_data", wb_data, 32'h1);
    chk("carry_flags2", {30'd0, flag_c, flag_z}, 32'd0);
    tick();

    // Bubble leaves flags and registers alone
    drive(CARD_ADD, 5'd0, 5'd0, 5'd15, 1'b1, 32'hFFFFFFFF, 2'b01);
    tick();
    drive(CARD_NOP, 5'd1, 5'd0, 5'd14, 1'b1, 32'h77, 2'b00);
    #1;
    chk("bubble_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle();
    chk("bubble_flags_set", {30'd0, flag_c, flag_z}, 32'd3);
    tick();
    peek(5'd14);
    chk("bubble_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("bubble_flags", {30'd0, flag_c, flag_z}, 32'd3);
    chk("bubble_dbg_x14", dbg_data, 32'h0);

    // Reset while an op sits in EX
    drive(CARD_ADD, 5'd0, 5'd0, 5'd16, 1'b1, 32'h99, 2'b00);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peek(5'd16);
    chk("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstmid_dbg_x16", dbg_data, 32'h0);
    chk("rstmid_alu_card", {27'd0, alu_Card}, 32'd0);
    chk("rstmid_flags", {30'd0, flag_c, flag_z}, 32'd0);
    tick();
    peek(5'd1);
    chk("rstmid_wb_after", {31'd0, wb_valid}, 32'd0);
    chk("rstmid_dbg_x1", dbg_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
